// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if
// Groups the stream and status signals of the PRBS checker.
//   din        : received stream bit
//   din_valid  : din qualifier
//   clear_cnt  : synchronous clear of err_count
//   locked     : checker is in LOCKED
//   bit_err    : one-cycle pulse per counted mismatch
//   err_count  : saturating mismatch count while locked
// master = stream source / controller side, slave = checker side.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
);
  logic             din;
  logic             din_valid;
  logic             clear_cnt;
  logic             locked;
  logic             bit_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output din, din_valid, clear_cnt,
    input  locked, bit_err, err_count
  );

  modport slave (
    input  din, din_valid, clear_cnt,
    output locked, bit_err, err_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker
// Receive-side checker for the 16-bit XNOR LFSR pattern generator.
// Self-synchronises to the incoming stream, declares lock, then
// flywheels its own copy of the sequence and counts bit errors.
//   clk    : system clock, all state updates on posedge
//   reset  : asynchronous, active-high
//   bus    : lfsr_checker_if.slave (din, din_valid, clear_cnt in;
//            locked, bit_err, err_count out)
//
// state  | meaning
// -------+----------------------------------------------------------
// HUNT   | filling hist with 16 valid bits, no compares
// SYNC   | comparing predictions, counting consecutive matches
// LOCKED | flywheeling prediction, counting errors, watching for loss
module lfsr_checker #(
  parameter int LOCK_COUNT  = 32,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_checker_if.slave bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_THRESH + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_THRESH - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic [3:0]       good_q, good_d;
  logic             locked_q, locked_d;
  logic             bit_err_q, bit_err_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic pred;
  logic hit;

  assign pred = ~(hist_q[0] ^ hist_q[1] ^ hist_q[3] ^ hist_q[12]);
  assign hit  = (bus.din == pred);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      bad_q     <= '0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      bit_err_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      bad_q     <= bad_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      bit_err_q <= bit_err_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    bad_d     = bad_q;
    good_d    = good_q;
    bit_err_d = 1'b0;
    err_d     = err_q;

    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          hist_d = {bus.din, hist_q[15:1]};
          fill_d = fill_q + 4'd1;
          if (fill_q == 4'd15) begin
            state_d = SYNC;
            match_d = '0;
          end
        end
        SYNC: begin
          hist_d = {bus.din, hist_q[15:1]};
          // all-ones history is the XNOR lockup point; a stuck-high line
          // would otherwise predict itself perfectly
          if (hit && (hist_q != 16'hFFFF)) begin
            if (match_q == LOCK_LAST) begin
              state_d = LOCKED;
              match_d = '0;
              bad_d   = '0;
              good_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // flywheel: a corrupted line bit never enters the history
          hist_d = {pred, hist_q[15:1]};
          if (!hit) begin
            bit_err_d = 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
            good_d = '0;
            if (bad_q == LOSS_LAST) begin
              state_d = HUNT;
              fill_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end else if (good_q == 4'd15) begin
            good_d = '0;
            bad_d  = '0;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (bus.clear_cnt) err_d = '0;
    locked_d = (state_d == LOCKED);
  end

  assign bus.locked    = locked_q;
  assign bus.bit_err   = bit_err_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;
  localparam int LOCK_COUNT  = 32;
  localparam int LOSS_THRESH = 8;
  localparam int CNT_W       = 16;
  localparam int M_HUNT = 0, M_SYNC = 1, M_LOCKED = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr_checker_if #(.CNT_W(CNT_W)) bus ();

  lfsr_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_THRESH(LOSS_THRESH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: stream history as a queue, oldest bit at index 0
  bit m_hist[$];
  int m_mode, m_fill, m_run, m_bad, m_good, m_errc;
  bit m_locked, m_bit_err;

  // generator window, oldest bit at index 0
  bit g_win[$];

  int vb, lock_vb, n_err_pulse, n_lock_cycles;
  bit seen_lock;

  function automatic void model_reset();
    m_hist = {};
    for (int i = 0; i < 16; i++) m_hist.push_back(1'b0);
    m_mode = M_HUNT;
    m_fill = 0; m_run = 0; m_bad = 0; m_good = 0; m_errc = 0;
    m_locked = 1'b0; m_bit_err = 1'b0;
  endfunction

  function automatic void model_step(input bit d, input bit v, input bit clr);
    bit p, ones;
    m_bit_err = 1'b0;
    if (v) begin
      p = ~(m_hist[0] ^ m_hist[1] ^ m_hist[3] ^ m_hist[12]);
      ones = 1'b1;
      foreach (m_hist[i]) if (!m_hist[i]) ones = 1'b0;
      case (m_mode)
        M_HUNT: begin
          m_hist.push_back(d);
          m_fill++;
          if (m_fill == 16) begin m_mode = M_SYNC; m_run = 0; end
        end
        M_SYNC: begin
          m_hist.push_back(d);
          if (d == p && !ones) m_run++; else m_run = 0;
          if (m_run == LOCK_COUNT) begin m_mode = M_LOCKED; m_bad = 0; m_good = 0; end
        end
        default: begin
          m_hist.push_back(p);
          if (d != p) begin
            m_bit_err = 1'b1;
            if (m_errc < (2 ** CNT_W) - 1) m_errc++;
            m_bad++;
            m_good = 0;
            if (m_bad == LOSS_THRESH) begin m_mode = M_HUNT; m_fill = 0; end
          end else begin
            m_good++;
            if (m_good == 16) begin m_bad = 0; m_good = 0; end
          end
        end
      endcase
      void'(m_hist.pop_front());
    end
    if (clr) m_errc = 0;
    m_locked = (m_mode == M_LOCKED);
  endfunction

  function automatic void gen_seed();
    logic [31:0] s;
    s = $urandom;
    if (s[15:0] == 16'hFFFF) s[0] = 1'b0;
    g_win = {};
    for (int i = 0; i < 16; i++) g_win.push_back(s[i]);
  endfunction

  function automatic bit gen_bit();
    bit b, nb;
    b  = g_win[0];
    nb = ~(g_win[0] ^ g_win[1] ^ g_win[3] ^ g_win[12]);
    void'(g_win.pop_front());
    g_win.push_back(nb);
    return b;
  endfunction

  function automatic void clear_stats();
    vb = 0; lock_vb = -1; seen_lock = 1'b0; n_err_pulse = 0; n_lock_cycles = 0;
  endfunction

  task automatic step(input bit d, input bit v, input bit clr);
    bus.din = d; bus.din_valid = v; bus.clear_cnt = clr;
    @(posedge clk);
    model_step(d, v, clr);
    if (v) vb++;
    #1;
    check_val("locked", bus.locked, m_locked);
    check_val("bit_err", bus.bit_err, m_bit_err);
    check_val("err_count", bus.err_count, m_errc);
    if (bus.bit_err) n_err_pulse++;
    if (bus.locked) n_lock_cycles++;
    if (bus.locked && !seen_lock) begin seen_lock = 1'b1; lock_vb = vb; end
  endtask

  task automatic clean(input int n, input bit rnd_valid);
    for (int i = 0; i < n; i++) begin
      if (!rnd_valid || $urandom_range(0, 1) == 1) step(gen_bit(), 1'b1, 1'b0);
      else step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic run_until_lock(input int budget, input bit rnd_valid);
    for (int i = 0; i < budget && !seen_lock; i++) clean(1, rnd_valid);
  endtask

  task automatic do_reset();
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.clear_cnt = 1'b0;
    reset = 1'b1;
    #20;
    reset = 1'b0;
    model_reset();
    clear_stats();
    check_val("rst_locked", bus.locked, 0);
    check_val("rst_bit_err", bus.bit_err, 0);
    check_val("rst_err_count", bus.err_count, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.clear_cnt = 1'b0;
    model_reset();
    clear_stats();

    // clean continuous stream
    do_reset();
    gen_seed();
    clean(1000, 1'b0);
    check_val("t1_lock_point", lock_vb, 48);
    check_val("t1_err_count", bus.err_count, 0);
    check_val("t1_err_pulses", n_err_pulse, 0);

    // single line error while locked
    n_err_pulse = 0;
    step(~gen_bit(), 1'b1, 1'b0);
    clean(100, 1'b0);
    check_val("t2_err_pulses", n_err_pulse, 1);
    check_val("t2_err_count", bus.err_count, 1);
    check_val("t2_locked", bus.locked, 1);

    // sustained errors force loss of lock, then relock
    step(gen_bit(), 1'b1, 1'b1);
    check_val("t3_cleared", bus.err_count, 0);
    for (int k = 0; k < LOSS_THRESH; k++) begin
      step(~gen_bit(), 1'b1, 1'b0);
      if (k != LOSS_THRESH - 1) clean(1 + $urandom_range(0, 13), 1'b0);
    end
    check_val("t3_locked_lost", bus.locked, 0);
    check_val("t3_err_count", bus.err_count, 8);
    clear_stats();
    run_until_lock(200, 1'b0);
    check_val("t3_relock_point", lock_vb, 48);

    // stuck-high line
    do_reset();
    for (int i = 0; i < 500; i++) step(1'b1, 1'b1, 1'b0);
    check_val("t4_lock_cycles", n_lock_cycles, 0);
    check_val("t4_err_count", bus.err_count, 0);

    // gappy valid, then clear coincident with an error
    do_reset();
    gen_seed();
    run_until_lock(400, 1'b1);
    check_val("t5_lock_point", lock_vb, 48);
    clean(50, 1'b1);
    check_val("t5_err_count", bus.err_count, 0);
    step(~gen_bit(), 1'b1, 1'b0);
    step(~gen_bit(), 1'b1, 1'b1);
    check_val("t5_clear_wins", bus.err_count, 0);
    clean(40, 1'b1);

    // asynchronous reset while locked with errors
    do_reset();
    gen_seed();
    run_until_lock(100, 1'b0);
    for (int k = 0; k < 5; k++) begin
      clean(20, 1'b0);
      step(~gen_bit(), 1'b1, 1'b0);
    end
    check_val("t6_err_count", bus.err_count, 5);
    check_val("t6_bit_err", bus.bit_err, 1);
    #2 reset = 1'b1;
    #1;
    check_val("t6_async_locked", bus.locked, 0);
    check_val("t6_async_bit_err", bus.bit_err, 0);
    check_val("t6_async_err_count", bus.err_count, 0);
    #2 reset = 1'b0;
    model_reset();
    clear_stats();
    run_until_lock(200, 1'b0);
    check_val("t6_relock_point", lock_vb, 48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
